// File: rtl/axis_serdes_pkg.sv
// axis_serdes_pkg: slice order and state types plus sizing helpers for the AXI-Stream width converters
package axis_serdes_pkg;
  typedef enum logic {LSB_FIRST = 1'b0, MSB_FIRST = 1'b1} slice_order_e;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} ser_state_e;
  function automatic int ratio_f(input int s_w, input int m_w);
    return s_w / m_w;
  endfunction
  function automatic int cnt_w_f(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction
endpackage

// File: rtl/axis_slice_sel.sv
// axis_slice_sel: finds the next kept slice after idx (or the first kept slice when start=1) in emission order
module axis_slice_sel import axis_serdes_pkg::*; #(
  parameter int RATIO = 4,
  parameter int CW = 2
) (
  input  logic [RATIO-1:0] keep,
  input  logic [CW-1:0]    idx,
  input  slice_order_e     order,
  input  logic             start,
  output logic [CW-1:0]    nxt,
  output logic             found
);
  // Scan from the far end toward the emission start so the kept slice closest to idx wins
  always_comb begin
    nxt = '0;
    found = 1'b0;
    for (int i = 0; i < RATIO; i++) begin
      if (order == MSB_FIRST) begin
        if (keep[CW'(i)] && (start || CW'(i) < idx)) begin
          nxt = CW'(i);
          found = 1'b1;
        end
      end else begin
        if (keep[CW'(RATIO - 1 - i)] && (start || CW'(RATIO - 1 - i) > idx)) begin
          nxt = CW'(RATIO - 1 - i);
          found = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/axis_width_serializer.sv
// axis_width_serializer: AXI-Stream width-down converter splitting S_W-bit words into M_W-bit slices
// Define AXIS_SER_TKEEP_EN to add s_axis_tkeep and skip slices whose keep bit is clear.
module axis_width_serializer #(
  parameter int S_AXIS_TDATA_WIDTH = 8,
  parameter int M_AXIS_TDATA_WIDTH = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic                                           clk,
  input  logic                                           aresetn,
  input  logic [S_AXIS_TDATA_WIDTH-1:0]                  s_axis_tdata,
  input  logic                                           s_axis_tvalid,
  input  logic                                           s_axis_tlast,
  output logic                                           s_axis_tready,
`ifdef AXIS_SER_TKEEP_EN
  input  logic [S_AXIS_TDATA_WIDTH/M_AXIS_TDATA_WIDTH-1:0] s_axis_tkeep,
`endif
  output logic [M_AXIS_TDATA_WIDTH-1:0]                  m_axis_tdata,
  output logic                                           m_axis_tvalid,
  output logic                                           m_axis_tlast,
  input  logic                                           m_axis_tready
);
  import axis_serdes_pkg::*;
  if (S_AXIS_TDATA_WIDTH % M_AXIS_TDATA_WIDTH != 0) begin : g_bad_width
    $fatal(1, "S_AXIS_TDATA_WIDTH must be an integer multiple of M_AXIS_TDATA_WIDTH");
  end
  localparam int RATIO = ratio_f(S_AXIS_TDATA_WIDTH, M_AXIS_TDATA_WIDTH);
  localparam int CW = cnt_w_f(RATIO);
  localparam logic [CW-1:0] FIRST_IDX = (MSB_FIRST != 0) ? CW'(RATIO - 1) : '0;
  ser_state_e state, state_d;
  logic [S_AXIS_TDATA_WIDTH-1:0] held, load_data;
  logic last_q;
  logic [CW-1:0] idx, load_idx, step_idx;
  logic is_final, take, accept, m_fire;
  assign accept = s_axis_tvalid && s_axis_tready;
  assign m_fire = m_axis_tvalid && m_axis_tready;
`ifdef AXIS_SER_TKEEP_EN
  localparam slice_order_e ORDER = (MSB_FIRST != 0) ? axis_serdes_pkg::MSB_FIRST : LSB_FIRST;
  logic [RATIO-1:0] keep_q;
  logic [CW-1:0] first_idx;
  logic in_any, more;
  axis_slice_sel #(.RATIO(RATIO), .CW(CW)) u_first (
    .keep(s_axis_tkeep), .idx({CW{1'b0}}), .order(ORDER), .start(1'b1), .nxt(first_idx), .found(in_any)
  );
  axis_slice_sel #(.RATIO(RATIO), .CW(CW)) u_next (
    .keep(keep_q), .idx(idx), .order(ORDER), .start(1'b0), .nxt(step_idx), .found(more)
  );
  assign is_final = !more;
  assign take = in_any || s_axis_tlast;
  assign load_data = in_any ? s_axis_tdata : '0;
  assign load_idx = in_any ? first_idx : FIRST_IDX;
  // An all-zero keep with tlast becomes a single zero slice so the packet end is never lost
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) keep_q <= '0;
    else if (accept && take) keep_q <= in_any ? s_axis_tkeep : RATIO'(1) << FIRST_IDX;
  end
`else
  localparam logic [CW-1:0] LAST_IDX = (MSB_FIRST != 0) ? '0 : CW'(RATIO - 1);
  assign is_final = idx == LAST_IDX;
  assign take = 1'b1;
  assign load_data = s_axis_tdata;
  assign load_idx = FIRST_IDX;
  assign step_idx = (MSB_FIRST != 0) ? idx - 1'b1 : idx + 1'b1;
`endif
  // State register
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else state <= state_d;
  end
  // A new word wins over draining so back-to-back words run without a bubble
  always_comb begin
    state_d = (accept && take) ? SHIFT : (m_fire && is_final) ? IDLE : state;
  end
  // Outputs: current slice, end-of-packet on the final slice only, ready when empty or draining
  always_comb begin
    m_axis_tvalid = state == SHIFT;
    m_axis_tdata = held[idx*M_AXIS_TDATA_WIDTH +: M_AXIS_TDATA_WIDTH];
    m_axis_tlast = m_axis_tvalid && last_q && is_final;
    s_axis_tready = (state == IDLE) || (m_axis_tvalid && is_final && m_axis_tready);
  end
  // Holding register and slice counter; the counter stops at the final slice
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      held <= '0;
      last_q <= 1'b0;
      idx <= '0;
    end else if (accept && take) begin
      held <= load_data;
      last_q <= s_axis_tlast;
      idx <= load_idx;
    end else if (m_fire && !is_final) begin
      idx <= step_idx;
    end
  end
endmodule

// File: tb/tb_axis_width_serializer.sv
// tb_axis_width_serializer: scoreboard bench over four serializer configurations
module tb_axis_width_serializer;
  localparam int P_SRDY = 0, P_MVALID = 1, P_MLAST = 2, P_MDATA = 3;
  typedef struct {int d; int sig; logic [7:0] exp; string name;} probe_t;
  logic clk = 1'b0;
  logic aresetn;
  logic [7:0] s_data [4];
  logic s_valid [4];
  logic s_last [4];
  logic s_ready [4];
  logic [7:0] m_data [4];
  logic m_valid [4];
  logic m_last [4];
  logic m_ready [4];
  logic m_data0;
  logic [3:0] m_data1;
  logic [1:0] m_data2;
`ifdef AXIS_SER_TKEEP_EN
  logic [1:0] keep1;
`endif
  logic [8:0] sq [4][$];
  probe_t pq [$];
  int checks = 0;
  int errors = 0;
  int timeouts = 0;
  int cyc = 0;
  logic done = 1'b0;
  logic hold_v [4];
  logic [8:0] hold_q [4];

  always #5 clk = ~clk;

  axis_width_serializer #(.S_AXIS_TDATA_WIDTH(8), .M_AXIS_TDATA_WIDTH(1), .MSB_FIRST(1)) u_d0 (
    .clk(clk), .aresetn(aresetn), .s_axis_tdata(s_data[0]), .s_axis_tvalid(s_valid[0]),
    .s_axis_tlast(s_last[0]), .s_axis_tready(s_ready[0]),
`ifdef AXIS_SER_TKEEP_EN
    .s_axis_tkeep(8'hFF),
`endif
    .m_axis_tdata(m_data0), .m_axis_tvalid(m_valid[0]), .m_axis_tlast(m_last[0]), .m_axis_tready(m_ready[0]));
  axis_width_serializer #(.S_AXIS_TDATA_WIDTH(8), .M_AXIS_TDATA_WIDTH(4), .MSB_FIRST(0)) u_d1 (
    .clk(clk), .aresetn(aresetn), .s_axis_tdata(s_data[1]), .s_axis_tvalid(s_valid[1]),
    .s_axis_tlast(s_last[1]), .s_axis_tready(s_ready[1]),
`ifdef AXIS_SER_TKEEP_EN
    .s_axis_tkeep(keep1),
`endif
    .m_axis_tdata(m_data1), .m_axis_tvalid(m_valid[1]), .m_axis_tlast(m_last[1]), .m_axis_tready(m_ready[1]));
  axis_width_serializer #(.S_AXIS_TDATA_WIDTH(8), .M_AXIS_TDATA_WIDTH(2), .MSB_FIRST(1)) u_d2 (
    .clk(clk), .aresetn(aresetn), .s_axis_tdata(s_data[2]), .s_axis_tvalid(s_valid[2]),
    .s_axis_tlast(s_last[2]), .s_axis_tready(s_ready[2]),
`ifdef AXIS_SER_TKEEP_EN
    .s_axis_tkeep(4'hF),
`endif
    .m_axis_tdata(m_data2), .m_axis_tvalid(m_valid[2]), .m_axis_tlast(m_last[2]), .m_axis_tready(m_ready[2]));
  axis_width_serializer #(.S_AXIS_TDATA_WIDTH(8), .M_AXIS_TDATA_WIDTH(8), .MSB_FIRST(1)) u_d3 (
    .clk(clk), .aresetn(aresetn), .s_axis_tdata(s_data[3]), .s_axis_tvalid(s_valid[3]),
    .s_axis_tlast(s_last[3]), .s_axis_tready(s_ready[3]),
`ifdef AXIS_SER_TKEEP_EN
    .s_axis_tkeep(1'b1),
`endif
    .m_axis_tdata(m_data[3]), .m_axis_tvalid(m_valid[3]), .m_axis_tlast(m_last[3]), .m_axis_tready(m_ready[3]));

  assign m_data[0] = {7'b0, m_data0};
  assign m_data[1] = {4'b0, m_data1};
  assign m_data[2] = {6'b0, m_data2};

  function automatic logic [7:0] sample(int d, int sig);
    case (sig)
      P_SRDY:   return {7'b0, s_ready[d]};
      P_MVALID: return {7'b0, m_valid[d]};
      P_MLAST:  return {7'b0, m_last[d]};
      default:  return m_data[d];
    endcase
  endfunction

  task automatic chk(string name, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  task automatic probe(int d, int sig, logic [7:0] e, string name);
    pq.push_back('{d, sig, e, $sformatf("%s_dut%0d", name, d)});
  endtask

  task automatic pushv(int d, logic [63:0] v, int n, int w, logic l);
    for (int k = 0; k < n; k++)
      sq[d].push_back({l && (k == n - 1), 8'((v >> (w * (n - 1 - k))) & ((64'd1 << w) - 64'd1))});
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(int d, logic [7:0] w, logic l);
    int n;
    s_data[d] = w;
    s_last[d] = l;
    s_valid[d] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_ready[d] && n < 50);
    if (!s_ready[d]) timeouts++;
    @(posedge clk);
    #1;
    s_valid[d] = 1'b0;
  endtask

  // Monitor: pops expected beats on every output handshake, checks probes and stall stability
  initial begin
    probe_t p;
    logic [8:0] e;
    for (int d = 0; d < 4; d++) hold_v[d] = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc > 20000) begin
        $display("FAIL watchdog got %0d cycles exp under 20000", cyc);
        $fatal(1);
      end
      while (pq.size() > 0) begin
        p = pq.pop_front();
        chk(p.name, {8'b0, sample(p.d, p.sig)}, {8'b0, p.exp});
      end
      for (int d = 0; d < 4; d++) begin
        if (aresetn && hold_v[d])
          chk($sformatf("stall_hold_dut%0d", d), {7'b0, m_valid[d], m_last[d], m_data[d]}, {7'b0, 1'b1, hold_q[d]});
        hold_v[d] = aresetn && m_valid[d] && !m_ready[d];
        hold_q[d] = {m_last[d], m_data[d]};
        if (aresetn && m_valid[d] && m_ready[d]) begin
          if (sq[d].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat_dut%0d got %h exp none", d, {m_last[d], m_data[d]});
          end else begin
            e = sq[d].pop_front();
            chk($sformatf("beat_dut%0d", d), {7'b0, m_last[d], m_data[d]}, {7'b0, e});
          end
        end
      end
      if (done) begin
        for (int d = 0; d < 4; d++) chk($sformatf("drained_dut%0d", d), 16'(sq[d].size()), 16'd0);
        chk("timeouts", 16'(timeouts), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  // Stimulus: directed vectors, expected beats pushed before each word is offered
  initial begin
    aresetn = 1'b0;
    for (int d = 0; d < 4; d++) begin
      s_data[d] = 8'h00;
      s_valid[d] = 1'b0;
      s_last[d] = 1'b0;
      m_ready[d] = 1'b1;
    end
`ifdef AXIS_SER_TKEEP_EN
    keep1 = 2'b11;
`endif
    idle(2);
    for (int d = 0; d < 4; d++) begin
      probe(d, P_MVALID, 8'd0, "rst_valid");
      probe(d, P_MLAST, 8'd0, "rst_last");
      probe(d, P_MDATA, 8'd0, "rst_data");
    end
    idle(1);
    aresetn = 1'b1;
    for (int d = 0; d < 4; d++) probe(d, P_SRDY, 8'd1, "rst_ready");
    idle(1);
    pushv(0, 64'b10101010, 8, 1, 1'b1);
    send(0, 8'hAA, 1'b1);
    idle(10);
    pushv(1, 64'h112233, 6, 4, 1'b1);
    send(1, 8'h11, 1'b0);
    fork
      begin
        for (int k = 0; k < 7; k++) begin
          probe(1, P_MVALID, 8'(k < 6), "no_gap");
          idle(1);
        end
      end
    join_none
    send(1, 8'h22, 1'b0);
    send(1, 8'h33, 1'b1);
    idle(10);
    pushv(2, 64'b00001111, 4, 2, 1'b1);
    send(2, 8'h0F, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      m_ready[2] = (k % 2) == 1;
      probe(2, P_SRDY, 8'(k >= 7), "stall_s_ready");
      probe(2, P_MLAST, 8'(k == 6 || k == 7), "stall_last");
      idle(1);
    end
    m_ready[2] = 1'b1;
    idle(3);
    pushv(0, 64'b010, 3, 1, 1'b0);
    send(0, 8'h5A, 1'b1);
    idle(3);
    aresetn = 1'b0;
    probe(0, P_MVALID, 8'd0, "mid_rst_valid");
    probe(0, P_MLAST, 8'd0, "mid_rst_last");
    idle(1);
    aresetn = 1'b1;
    probe(0, P_SRDY, 8'd1, "post_rst_ready");
    idle(1);
    pushv(0, 64'hC3, 8, 1, 1'b1);
    send(0, 8'hC3, 1'b1);
    idle(10);
    pushv(3, 64'h11223344556677, 7, 8, 1'b1);
    send(3, 8'h11, 1'b0);
    probe(3, P_MDATA, 8'h11, "pass_latency");
    for (int b = 2; b <= 7; b++) send(3, 8'(b * 17), b == 7);
    idle(5);
`ifdef AXIS_SER_TKEEP_EN
    pushv(1, 64'h4, 1, 4, 1'b1);
    keep1 = 2'b01;
    send(1, 8'hE4, 1'b1);
    pushv(1, 64'hE, 1, 4, 1'b1);
    keep1 = 2'b10;
    send(1, 8'hE4, 1'b1);
    keep1 = 2'b00;
    send(1, 8'h5A, 1'b0);
    probe(1, P_MVALID, 8'd0, "keep_drop_valid");
    probe(1, P_SRDY, 8'd1, "keep_drop_ready");
    pushv(1, 64'h0, 1, 4, 1'b1);
    send(1, 8'h5A, 1'b1);
    keep1 = 2'b11;
    idle(5);
`endif
    done = 1'b1;
  end
endmodule
